// File: rtl/glitch_sweep_ctrl.sv
// Wishbone master that sweeps a glitch_wb over delay (inner loop) and width (outer loop).
// Optional external trigger gate before each ARM write: define GLITCH_SWEEP_EXTTRIG_EN.
module glitch_sweep_ctrl #(
  parameter int ACK_TIMEOUT = 16,
  parameter int POLL_MAX    = 1024,
  parameter int HOLDOFF     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] d_start_i,
  input  logic [15:0] d_end_i,
  input  logic [15:0] d_step_i,
  input  logic [7:0]  w_start_i,
  input  logic [7:0]  w_end_i,
  input  logic [7:0]  w_step_i,
  input  logic [7:0]  mode_i,
`ifdef GLITCH_SWEEP_EXTTRIG_EN
  input  logic        ext_trig_i,
`endif
  output logic [5:2]  adr_o,
  output logic [7:0]  dat_o,
  output logic        we_o,
  output logic        stb_o,
  input  logic [7:0]  dat_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] cur_delay_o,
  output logic [7:0]  cur_width_o,
  output logic [23:0] points_o
);

  // glitch_wb register address codes
  localparam logic [3:0] ADR_STATUS = 4'h0;
  localparam logic [3:0] ADR_MODE   = 4'h1;
  localparam logic [3:0] ADR_DELAY0 = 4'h2;
  localparam logic [3:0] ADR_DELAY1 = 4'h3;
  localparam logic [3:0] ADR_WIDTH  = 4'h4;

  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [3:0] {
    IDLE, CFG_MODE, WR_D0, WR_D1, WR_W, ARM, POLL, HOLD, NEXT, ERR
`ifdef GLITCH_SWEEP_EXTTRIG_EN
    , WAIT_TRIG
`endif
  } state_t;

  state_t              state;
  logic                pend;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [15:0]         d_start_r, d_end_r, d_step_r;
  logic [7:0]          w_end_r, w_step_r, mode_r;

  logic [3:0]          acc_adr;
  logic [7:0]          acc_dat;
  logic                acc_we;
  logic [16:0]         d_sum;
  logic [8:0]          w_sum;
  logic                unused_dat;

  assign unused_dat = ^dat_i[7:1];

  // Extra carry bit so an increment past 16'hFFFF / 8'hFF still ends the axis
  assign d_sum = {1'b0, cur_delay_o} + {1'b0, d_step_r};
  assign w_sum = {1'b0, cur_width_o} + {1'b0, w_step_r};

`ifdef GLITCH_SWEEP_EXTTRIG_EN
  logic [2:0] trig_sync;
  logic       trig_rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) trig_sync <= 3'b000;
    else       trig_sync <= {trig_sync[1:0], ext_trig_i};
  end

  assign trig_rise = trig_sync[1] & ~trig_sync[2];
`endif

  always_comb begin
    acc_adr = ADR_STATUS;
    acc_dat = 8'h00;
    acc_we  = 1'b1;
    case (state)
      CFG_MODE: begin acc_adr = ADR_MODE;   acc_dat = mode_r;            end
      WR_D0:    begin acc_adr = ADR_DELAY0; acc_dat = cur_delay_o[7:0];  end
      WR_D1:    begin acc_adr = ADR_DELAY1; acc_dat = cur_delay_o[15:8]; end
      WR_W:     begin acc_adr = ADR_WIDTH;  acc_dat = cur_width_o;       end
      ARM:      acc_dat = 8'h01;
      POLL:     acc_we  = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pend        <= 1'b0;
      tmo_cnt     <= '0;
      poll_cnt    <= '0;
      hold_cnt    <= '0;
      d_start_r   <= '0;
      d_end_r     <= '0;
      d_step_r    <= '0;
      w_end_r     <= '0;
      w_step_r    <= '0;
      mode_r      <= '0;
      adr_o       <= '0;
      dat_o       <= '0;
      we_o        <= 1'b0;
      stb_o       <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      cur_delay_o <= '0;
      cur_width_o <= '0;
      points_o    <= '0;
    end else begin
      done_o <= 1'b0;
      stb_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if ((d_start_i > d_end_i) || (w_start_i > w_end_i)) begin
              err_o <= 1'b1;
            end else begin
              d_start_r   <= d_start_i;
              d_end_r     <= d_end_i;
              d_step_r    <= (d_step_i == 16'd0) ? 16'd1 : d_step_i;
              w_end_r     <= w_end_i;
              w_step_r    <= (w_step_i == 8'd0) ? 8'd1 : w_step_i;
              mode_r      <= mode_i;
              cur_delay_o <= d_start_i;
              cur_width_o <= w_start_i;
              err_o       <= 1'b0;
              points_o    <= '0;
              pend        <= 1'b0;
              busy_o      <= 1'b1;
              state       <= CFG_MODE;
            end
          end
        end

        CFG_MODE, WR_D0, WR_D1, WR_W, ARM, POLL: begin
          if (!pend) begin
            if (abort_i) begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              stb_o   <= 1'b1;
              pend    <= 1'b1;
              tmo_cnt <= '0;
              adr_o   <= acc_adr;
              dat_o   <= acc_dat;
              we_o    <= acc_we;
            end
          end else if (!stb_o) begin
            // Only cycles after the strobe count toward the ack window
            if (ack_i) begin
              pend <= 1'b0;
              if (abort_i) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                case (state)
                  CFG_MODE: state <= WR_D0;
                  WR_D0:    state <= WR_D1;
                  WR_D1:    state <= WR_W;
`ifdef GLITCH_SWEEP_EXTTRIG_EN
                  WR_W:     state <= WAIT_TRIG;
`else
                  WR_W:     state <= ARM;
`endif
                  ARM: begin
                    state    <= POLL;
                    stb_o    <= 1'b1;
                    pend     <= 1'b1;
                    tmo_cnt  <= '0;
                    adr_o    <= ADR_STATUS;
                    dat_o    <= 8'h00;
                    we_o     <= 1'b0;
                    poll_cnt <= POLL_W'(1);
                  end
                  POLL: begin
                    if (dat_i[0]) begin
                      if (points_o != 24'hFF_FFFF) points_o <= points_o + 24'd1;
                      hold_cnt <= '0;
                      state    <= HOLD;
                    end else if (poll_cnt == POLL_LAST) begin
                      state <= ERR;
                    end else begin
                      stb_o    <= 1'b1;
                      pend     <= 1'b1;
                      tmo_cnt  <= '0;
                      poll_cnt <= poll_cnt + 1'b1;
                    end
                  end
                  default: state <= IDLE;
                endcase
              end
            end else if (tmo_cnt == TMO_LAST) begin
              pend  <= 1'b0;
              state <= ERR;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

`ifdef GLITCH_SWEEP_EXTTRIG_EN
        WAIT_TRIG: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (trig_rise) begin
            state <= ARM;
          end
        end
`endif

        HOLD: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= NEXT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        NEXT: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (d_sum <= {1'b0, d_end_r}) begin
            cur_delay_o <= d_sum[15:0];
            state       <= WR_D0;
          end else begin
            cur_delay_o <= d_start_r;
            if (w_sum <= {1'b0, w_end_r}) begin
              cur_width_o <= w_sum[7:0];
              state       <= WR_D0;
            end else begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end

        ERR: begin
          err_o  <= 1'b1;
          busy_o <= 1'b0;
          pend   <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
